// File: rtl/calc_pkg.sv
// Shared calculator definitions: debouncer state encoding and default qualification length.
package calc_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin in, debounced level and press/release strobes out.
interface button_debouncer_if;

  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the progress push-button: synchronise, qualify each edge for DEBOUNCE_CYCLES
// stable cycles, then emit a clean level plus one-cycle press/release strobes.
module button_debouncer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync;
  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic busy_q, busy_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (sync)
  );

  // Next state; the counter restarts from zero whenever the state changes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_TERM) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.busy          = busy_q;

endmodule
